// File: rtl/fpro_debug_vjtag_pkg.sv
// Shared types and constants for the virtual-JTAG debug host.
// Holds the FSM state encoding, strobe bundle and the debug-slave IR codes.
package fpro_debug_vjtag_pkg;

   localparam int DR_WIDTH_DEFAULT = 38;

   localparam logic [1:0] IR_OCIMEM    = 2'd0;
   localparam logic [1:0] IR_TRACEMEM  = 2'd1;
   localparam logic [1:0] IR_BREAK     = 2'd2;
   localparam logic [1:0] IR_TRACECTRL = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_UIR,
      ST_CDR,
      ST_SDR,
      ST_UDR,
      ST_RTI,
      ST_RSP
   } vjtag_state_t;

   typedef struct packed {
      logic uir;
      logic cdr;
      logic sdr;
      logic udr;
      logic rti;
   } vji_stb_t;

   // IDLE and RSP present as run-test-idle to the slave, alongside RTI.
   function automatic vji_stb_t stb_of(input vjtag_state_t s);
      vji_stb_t r;
      r = '0;
      case (s)
         ST_UIR:  r.uir = 1'b1;
         ST_CDR:  r.cdr = 1'b1;
         ST_SDR:  r.sdr = 1'b1;
         ST_UDR:  r.udr = 1'b1;
         default: r.rti = 1'b1;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/fpro_debug_vjtag_tck_gen.sv
// Test-clock divider: low phase then high phase, TCK_DIV clk cycles each.
// Latency: tck_rise/tck_fall are combinational pulses in the clk cycle that flips tck.
// Backpressure: none; dropping en parks tck low and restarts at a fresh low phase.
module fpro_debug_vjtag_tck_gen #(
   parameter int TCK_DIV = 2
) (
   input  logic clk,
   input  logic reset_n,
   input  logic en,
   output logic tck,
   output logic tck_rise,
   output logic tck_fall
);

   localparam int CW = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TCK_DIV - 1);

   logic [CW-1:0] cnt;
   logic          phase;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt   <= '0;
         phase <= 1'b0;
      end else if (!en) begin
         cnt   <= '0;
         phase <= 1'b0;
      end else if (cnt == LAST) begin
         cnt   <= '0;
         phase <= ~phase;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   assign tck      = phase;
   assign tck_rise = en & ~phase & (cnt == LAST);
   assign tck_fall = en &  phase & (cnt == LAST);

endmodule

// File: rtl/fpro_debug_vjtag_host.sv
// Virtual-JTAG initiator for the debug slave: one IR+DR command in, captured DR out.
// Latency: rsp_valid rises (DR_WIDTH+3)*2*TCK_DIV clk cycles after accept.
// Backpressure: response held until rsp_ready in RSP; cmd_ready low from accept to IDLE.
module fpro_debug_vjtag_host
   import fpro_debug_vjtag_pkg::*;
#(
   parameter int DR_WIDTH  = DR_WIDTH_DEFAULT,
   parameter int IR_WIDTH  = 2,
   parameter int TCK_DIV   = 2,
   parameter int IDLE_TCKS = 2
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [IR_WIDTH-1:0] cmd_ir,
   input  logic [DR_WIDTH-1:0] cmd_wdata,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [DR_WIDTH-1:0] rsp_rdata,
   output logic                vji_tck,
   output logic                vji_tdi,
   input  logic                vji_tdo,
   output logic [IR_WIDTH-1:0] vji_ir_in,
   input  logic [IR_WIDTH-1:0] vji_ir_out,
   output logic                vji_uir,
   output logic                vji_cdr,
   output logic                vji_sdr,
   output logic                vji_udr,
   output logic                vji_rti
);

   localparam int TW = $clog2(DR_WIDTH + IDLE_TCKS + 1);

   vjtag_state_t        state;
   vji_stb_t            stb;
   logic [DR_WIDTH-1:0] shift;
   logic [TW-1:0]       tck_cnt;
   logic                tck_en;
   logic                tck_rise;
   logic                tck_fall;
   logic                unused_ir_out;

   assign unused_ir_out = ^vji_ir_out;
   assign tck_en = (state != ST_IDLE) && (state != ST_RSP);

   fpro_debug_vjtag_tck_gen #(
      .TCK_DIV (TCK_DIV)
   ) u_tck_gen (
      .clk      (clk),
      .reset_n  (reset_n),
      .en       (tck_en),
      .tck      (vji_tck),
      .tck_rise (tck_rise),
      .tck_fall (tck_fall)
   );

   // Transitions happen on tck_fall, i.e. at the start of the next low phase.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= ST_IDLE;
         stb       <= stb_of(ST_IDLE);
         cmd_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         shift     <= '0;
         tck_cnt   <= '0;
         vji_tdi   <= 1'b0;
         vji_ir_in <= '0;
      end else begin
         if (tck_rise && state == ST_SDR)
            shift <= {vji_tdo, shift[DR_WIDTH-1:1]};
         case (state)
            ST_IDLE: if (cmd_valid && cmd_ready) begin
               shift     <= cmd_wdata;
               vji_ir_in <= cmd_ir;
               cmd_ready <= 1'b0;
               state     <= ST_UIR;
               stb       <= stb_of(ST_UIR);
            end
            ST_UIR: if (tck_fall) begin
               state <= ST_CDR;
               stb   <= stb_of(ST_CDR);
            end
            ST_CDR: if (tck_fall) begin
               state   <= ST_SDR;
               stb     <= stb_of(ST_SDR);
               tck_cnt <= '0;
               vji_tdi <= shift[0];
            end
            ST_SDR: if (tck_fall) begin
               if (tck_cnt == TW'(DR_WIDTH - 1)) begin
                  state   <= ST_UDR;
                  stb     <= stb_of(ST_UDR);
                  vji_tdi <= 1'b0;
               end else begin
                  tck_cnt <= tck_cnt + 1'b1;
                  vji_tdi <= shift[0];
               end
            end
            ST_UDR: if (tck_fall) begin
               rsp_rdata <= shift;
               rsp_valid <= 1'b1;
               tck_cnt   <= '0;
               if (IDLE_TCKS == 0) begin
                  state <= ST_RSP;
                  stb   <= stb_of(ST_RSP);
               end else begin
                  state <= ST_RTI;
                  stb   <= stb_of(ST_RTI);
               end
            end
            ST_RTI: if (tck_fall) begin
               if (tck_cnt == TW'(IDLE_TCKS - 1)) begin
                  state <= ST_RSP;
                  stb   <= stb_of(ST_RSP);
               end else begin
                  tck_cnt <= tck_cnt + 1'b1;
               end
            end
            ST_RSP: if (rsp_ready) begin
               rsp_valid <= 1'b0;
               cmd_ready <= 1'b1;
               state     <= ST_IDLE;
               stb       <= stb_of(ST_IDLE);
            end
            default: begin
               state <= ST_IDLE;
               stb   <= stb_of(ST_IDLE);
            end
         endcase
      end
   end

   assign vji_uir = stb.uir;
   assign vji_cdr = stb.cdr;
   assign vji_sdr = stb.sdr;
   assign vji_udr = stb.udr;
   assign vji_rti = stb.rti;

endmodule
